pulse_train_gen: RTL and testbench

//  Transmit-side companion to the positive-edge detector: converts single-cycle trigger requests

---
 rtl/pulse_train_gen_pkg.sv | 35 +++
 rtl/pulse_phase_timer.sv | 45 ++++
 rtl/pulse_train_gen.sv | 188 ++++++++++++++++++
 tb/tb_pulse_train_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_train_gen_pkg.sv
// ---------------------------------------------------------------------------
// pulse_train_gen_pkg
//
// Purpose:
//    Shared definitions for the pulse-train generator: the FSM state
//    encoding and a helper that sizes the phase counter from the high and
//    low widths.
//
// Contents:
//    pt_state_e       IDLE / HIGH / LOW state encoding (2'd3 is illegal)
//    ptMax            larger of two integers
//    ptPhaseWidth     counter width able to hold max(HIGH_W, LOW_W)
// ---------------------------------------------------------------------------
package pulse_train_gen_pkg;

    // The fourth code of the 2-bit state register is never entered on
    // purpose. If it ever appears, the top recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } pt_state_e;

    // Larger of two integers. Used at elaboration time only.
    function automatic int ptMax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The phase counter is loaded with width-1 and only counts down.
    // Sizing it to hold max+1 keeps it valid when both widths are 1.
    function automatic int ptPhaseWidth(input int highW, input int lowW);
        return $clog2(ptMax(highW, lowW) + 1);
    endfunction

endpackage

// File: rtl/pulse_phase_timer.sv
// ---------------------------------------------------------------------------
// pulse_phase_timer
//
// Purpose:
//    Down-counter that times one HIGH or LOW phase of the pulse train. The
//    owner loads it with (phase length - 1) on the edge that enters the
//    phase. The zero flag then marks the last cycle of that phase.
//
// Ports:
//    i_clk       rising-edge clock
//    i_rst       synchronous, active-high reset (counter cleared)
//    i_load      load strobe; takes priority over counting
//    i_loadVal   value loaded on i_load
//    i_en        count enable; decrements while non-zero
//    o_zero      counter is zero (current phase ends at the next edge)
// ---------------------------------------------------------------------------
module pulse_phase_timer #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_loadVal,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // A load always wins, so a phase can start on the same edge that ends
    // the previous one. Counting saturates at zero. The counter holds zero
    // until the owner reloads it, which keeps the zero flag stable.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// ---------------------------------------------------------------------------
// pulse_train_gen
//
// Purpose:
//    Turns single-cycle burst requests into clean pulse trains on o_sig.
//    Each pulse is HIGH_W cycles high followed by LOW_W cycles low, so a
//    downstream positive-edge detector sees exactly one rising edge per
//    pulse. One further request can wait in a single pending slot while a
//    burst is in flight.
//
// Parameters:
//    HIGH_W   cycles o_sig is held high per pulse (>= 1)
//    LOW_W    cycles o_sig is held low after each pulse, incl. last (>= 1)
//    CNT_W    width of i_num; bursts of 1 .. 2^CNT_W-1 pulses
//
// Ports:
//    i_clk        rising-edge clock
//    i_rst        synchronous, active-high reset
//    i_trig       one-cycle burst request
//    i_num        pulses in the requested burst (0 = request ignored)
//    o_sig        registered pulse-train output
//    o_busy       generator is not idle
//    o_pend_full  pending slot holds a request
//    o_done       one-cycle pulse: a burst's final low phase completed
//    o_drop       one-cycle pulse: request rejected (busy, slot full)
// ---------------------------------------------------------------------------
module pulse_train_gen
    import pulse_train_gen_pkg::*;
#(
    parameter int HIGH_W = 2,
    parameter int LOW_W  = 2,
    parameter int CNT_W  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_trig,
    input  logic [CNT_W-1:0] i_num,
    output logic             o_sig,
    output logic             o_busy,
    output logic             o_pend_full,
    output logic             o_done,
    output logic             o_drop
);

    localparam int PH_W = ptPhaseWidth(HIGH_W, LOW_W);

    localparam logic [PH_W-1:0] HIGH_LOAD = PH_W'(HIGH_W - 1);
    localparam logic [PH_W-1:0] LOW_LOAD  = PH_W'(LOW_W - 1);

    pt_state_e        r_state;
    logic [CNT_W-1:0] r_pulsesLeft;
    logic [CNT_W-1:0] r_slotNum;
    logic             r_pendFull;
    logic             r_sig;
    logic             r_busy;
    logic             r_done;
    logic             r_drop;

    logic             w_trigValid;
    logic             w_active;
    logic             w_start;
    logic             w_phaseZero;
    logic             w_phaseEnd;
    logic             w_timerLoad;
    logic [PH_W-1:0]  w_timerLoadVal;

    // A request with a zero pulse count never has any effect. Filtering it
    // here means pulses_left is never loaded with zero and cannot underflow.
    assign w_trigValid = i_trig && (i_num != '0);

    // HIGH and LOW are the only states in which the phase timer runs.
    assign w_active = (r_state == ST_HIGH) || (r_state == ST_LOW);

    // Starting from idle and finishing any phase are the two moments that
    // (re)arm the timer.
    assign w_start    = (r_state == ST_IDLE) && w_trigValid;
    assign w_phaseEnd = w_active && w_phaseZero;

    // The timer is reloaded at every phase boundary. The value depends only
    // on the phase being entered: leaving HIGH enters LOW. Every other
    // boundary enters HIGH. When a burst ends with nothing pending, the
    // reload is harmless because the timer is ignored in IDLE.
    assign w_timerLoad    = w_start || w_phaseEnd;
    assign w_timerLoadVal = (r_state == ST_HIGH) ? LOW_LOAD : HIGH_LOAD;

    // A single down-counter is shared by both phases. It is reloaded on each
    // HIGH/LOW entry.
    pulse_phase_timer #(
        .W(PH_W)
    ) u_phaseTimer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_timerLoad),
        .i_loadVal (w_timerLoadVal),
        .i_en      (w_active),
        .o_zero    (w_phaseZero)
    );

    // Main FSM together with the burst counter, the pending slot and the
    // done/drop strobes. All outputs come straight from registers, so o_sig
    // is glitch-free and has a one-cycle latency from the request.
    //
    // The pending-slot decision looks only at the registered slot flag. A
    // request that arrives on the same edge as the slot is consumed
    // therefore still sees the slot full and is dropped. The consume path
    // and the write path are mutually exclusive because one needs the flag
    // set and the other needs it clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_pulsesLeft <= '0;
            r_slotNum    <= '0;
            r_pendFull   <= 1'b0;
            r_sig        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_drop <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_trigValid) begin
                        r_state      <= ST_HIGH;
                        r_sig        <= 1'b1;
                        r_busy       <= 1'b1;
                        r_pulsesLeft <= i_num;
                    end
                end

                ST_HIGH: begin
                    if (w_phaseZero) begin
                        r_state <= ST_LOW;
                        r_sig   <= 1'b0;
                    end
                end

                ST_LOW: begin
                    if (w_phaseZero) begin
                        if (r_pulsesLeft != CNT_W'(1)) begin
                            r_state      <= ST_HIGH;
                            r_sig        <= 1'b1;
                            r_pulsesLeft <= r_pulsesLeft - CNT_W'(1);
                        end else begin
                            r_done <= 1'b1;
                            if (r_pendFull) begin
                                r_state      <= ST_HIGH;
                                r_sig        <= 1'b1;
                                r_pulsesLeft <= r_slotNum;
                                r_pendFull   <= 1'b0;
                            end else begin
                                r_state      <= ST_IDLE;
                                r_busy       <= 1'b0;
                                r_pulsesLeft <= '0;
                            end
                        end
                    end
                end

                default: begin
                    r_state      <= ST_IDLE;
                    r_sig        <= 1'b0;
                    r_busy       <= 1'b0;
                    r_pulsesLeft <= '0;
                    r_pendFull   <= 1'b0;
                    r_slotNum    <= '0;
                end
            endcase

            if (w_active && w_trigValid) begin
                if (r_pendFull) begin
                    r_drop <= 1'b1;
                end else begin
                    r_slotNum  <= i_num;
                    r_pendFull <= 1'b1;
                end
            end
        end
    end

    assign o_sig       = r_sig;
    assign o_busy      = r_busy;
    assign o_pend_full = r_pendFull;
    assign o_done      = r_done;
    assign o_drop      = r_drop;

endmodule

// File: tb/tb_pulse_train_gen.sv
// ---------------------------------------------------------------------------
// tb_pulse_train_gen
//
// Purpose:
//    Self-checking bench for pulse_train_gen with HIGH_W=2, LOW_W=3 and
//    CNT_W=4. A table of per-cycle vectors holds the inputs and the expected
//    outputs. A burst scoreboard also tracks the pulse count of each
//    accepted request and checks it when that burst reports done.
// ---------------------------------------------------------------------------
module tb_pulse_train_gen;

    localparam int HW     = 2;
    localparam int LW     = 3;
    localparam int CW     = 4;
    localparam int PERIOD = HW + LW;

    typedef struct {
        bit          trig;
        logic [CW-1:0] num;
        bit          acc;
        bit          sig;
        bit          busy;
        bit          pend;
        bit          done;
        bit          drop;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          trig;
    logic [CW-1:0] num;
    logic          sig;
    logic          busy;
    logic          pendFull;
    logic          done;
    logic          drop;

    vec_t vecQ[$];
    int   expBurstQ[$];
    int   riseCount = 0;
    logic prevSig = 1'b0;
    int   nCompared = 0;
    int   nMismatched = 0;

    pulse_train_gen #(
        .HIGH_W(HW),
        .LOW_W (LW),
        .CNT_W (CW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_trig      (trig),
        .i_num       (num),
        .o_sig       (sig),
        .o_busy      (busy),
        .o_pend_full (pendFull),
        .o_done      (done),
        .o_drop      (drop)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    // Appends one per-cycle vector to the table.
    function automatic void addVec(input bit t, input logic [CW-1:0] n, input bit acc,
                                   input bit eSig, input bit eBusy, input bit ePend,
                                   input bit eDone, input bit eDrop);
        vec_t v;
        v.trig = t;
        v.num  = n;
        v.acc  = acc;
        v.sig  = eSig;
        v.busy = eBusy;
        v.pend = ePend;
        v.done = eDone;
        v.drop = eDrop;
        vecQ.push_back(v);
    endfunction

    // A lone burst of n pulses started from idle. It is high for the first
    // HW cycles of every PERIOD, reports done after n*PERIOD cycles and is
    // then idle again.
    function automatic void addSolo(input int n);
        addVec(1'b1, CW'(n), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int t = 1; t < n * PERIOD; t++) begin
            addVec(1'b0, '0, 1'b0, ((t % PERIOD) < HW), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        addVec(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        addVec(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // Compares one output bit and records the result.
    task automatic checkBit(input string name, input logic act, input logic exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs and advances to just after the next edge.
    // Accepted requests are pushed to the burst scoreboard. A reset clears
    // the scoreboard because any burst in flight is aborted.
    task automatic applyStimulus(input bit r, input bit t, input logic [CW-1:0] n,
                                 input bit acc);
        rst  = r;
        trig = t;
        num  = n;
        if (acc) expBurstQ.push_back(int'(n));
        @(posedge clk);
        #1;
        rst  = 1'b0;
        trig = 1'b0;
        num  = '0;
        if (r) begin
            expBurstQ.delete();
            riseCount = 0;
        end
    endtask

    // Compares all outputs against the expected values. It then updates the
    // burst scoreboard: on done, the rising edges counted since the previous
    // done must match the oldest accepted request.
    task automatic checkOutput(input string tag, input bit eSig, input bit eBusy,
                               input bit ePend, input bit eDone, input bit eDrop);
        int expPulses;
        checkBit({tag, ".sig"},       sig,      eSig);
        checkBit({tag, ".busy"},      busy,     eBusy);
        checkBit({tag, ".pend_full"}, pendFull, ePend);
        checkBit({tag, ".done"},      done,     eDone);
        checkBit({tag, ".drop"},      drop,     eDrop);
        if (done === 1'b1) begin
            nCompared++;
            if (expBurstQ.size() == 0) begin
                nMismatched++;
                $display("[TB] FAIL %s.burst: got done, expected no burst outstanding", tag);
            end else begin
                expPulses = expBurstQ.pop_front();
                if (riseCount != expPulses) begin
                    nMismatched++;
                    $display("[TB] FAIL %s.burst pulses: got %0d, expected %0d",
                             tag, riseCount, expPulses);
                end
            end
            riseCount = 0;
        end
        if ((sig === 1'b1) && (prevSig !== 1'b1)) riseCount++;
        prevSig = sig;
    endtask

    initial begin
        rst  = 1'b1;
        trig = 1'b0;
        num  = '0;

        // Idle checks: a zero-count request must do nothing.
        addVec(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        addVec(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single pulse, three pulses, and the largest burst.
        addSolo(1);
        addSolo(3);
        addSolo(15);

        // Two bursts back to back through the pending slot. A zero-count
        // request while busy must not fill the slot.
        addVec(1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        addVec(1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        addVec(1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Full slot: the third request drops, and a zero-count request does
        // not. A request on the slot-consuming edge is also dropped.
        addVec(1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        addVec(1'b1, 4'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        addVec(1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        addVec(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addVec(1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        addVec(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        addVec(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state.
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Table-driven vectors.
        for (int i = 0; i < vecQ.size(); i++) begin
            applyStimulus(1'b0, vecQ[i].trig, vecQ[i].num, vecQ[i].acc);
            checkOutput($sformatf("v%0d", i), vecQ[i].sig, vecQ[i].busy,
                        vecQ[i].pend, vecQ[i].done, vecQ[i].drop);
        end

        // Reset in the middle of a 4-pulse burst while a request is pending:
        // the burst and the slot are gone, no done appears, and a new
        // request starts cleanly.
        applyStimulus(1'b0, 1'b1, 4'd4, 1'b1);
        checkOutput("mid.e0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        checkOutput("mid.e1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'd1, 1'b1);
        checkOutput("mid.e2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        checkOutput("mid.e3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        checkOutput("mid.e4", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        checkOutput("mid.e5", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
        checkOutput("mid.e6", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        checkOutput("mid.e7", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'd1, 1'b1);
        checkOutput("mid.e8", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        checkOutput("mid.e9", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int e = 10; e < 13; e++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
            checkOutput($sformatf("mid.e%0d", e), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        checkOutput("mid.e13", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        checkOutput("mid.e14", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Every accepted burst must have reported done.
        nCompared++;
        if (expBurstQ.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL bursts outstanding: got %0d, expected 0", expBurstQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
